// File: rtl/config_pkg.sv
// Shared definitions for the uart_alu block: command opcodes, parser
// state encoding, arithmetic mode and the bit-period helper.
package config_pkg;

  localparam logic [7:0] OP_ECHO  = 8'hEC;
  localparam logic [7:0] OP_ADD32 = 8'h10;
  localparam logic [7:0] OP_MUL32 = 8'h11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RSVD,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_EXEC,
    ST_RESP
  } parser_state_t;

  typedef enum logic [1:0] {
    MODE_ECHO,
    MODE_ADD,
    MODE_MUL
  } mode_t;

  // Whole core clocks per serial bit, rounded down.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_alu_if.sv
// Pin-level bundle of the uart_alu block.
//   rxd_i  : serial receive line into the block, idle high
//   txd_o  : serial transmit line out of the block, idle high
//   busy_o : block is handling a packet or still sending its response
// master = host side (drives rxd_i), slave = uart_alu.
interface uart_alu_if;
  logic rxd_i;
  logic txd_o;
  logic busy_o;

  modport master (output rxd_i, input txd_o, input busy_o);
  modport slave  (input rxd_i, output txd_o, output busy_o);
endinterface

// File: rtl/uart_alu_serdes.sv
// 8N1 UART bit engines with byte-strobe interfaces.
//   clk_i, rst_i : core clock, async active-high reset
//   rxd          : raw serial input (synchronised here)
//   rx_data      : received byte, valid while rx_valid pulses for 1 cycle
//   tx_data      : byte to send, accepted when tx_valid && tx_ready
//   tx_ready     : transmitter idle and able to take a byte
//   tx_active    : a frame is on the line
//   txd          : registered serial output
module uart_alu_serdes #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_active,
  output logic       txd
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------- receiver ----------------
  rx_state_t        rx_state;
  logic [1:0]       rx_sync;
  logic             rx_prev;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], rxd};
      rx_prev  <= rx_sync[1];
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync[1]) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          // Mid-bit confirmation; a high line here was only a glitch.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_sync[1] ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync[1], rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            // A low stop bit is a framing error: the byte is dropped.
            if (rx_sync[1]) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;

  assign tx_ready  = (tx_state == TX_IDLE);
  assign tx_active = (tx_state != TX_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          txd <= 1'b1;
          if (tx_valid) begin
            tx_shift <= tx_data;
            txd      <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              txd      <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) tx_state <= TX_IDLE;
          else                    tx_cnt   <= tx_cnt + CNT_W'(1);
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_alu.sv
// Serial-attached arithmetic block. Parses packets
//   opcode, reserved, len_lo, len_hi, (len-4) payload bytes
// arriving on the UART and answers with ECHO / ADD32 / MUL32 results.
//   clk_i, rst_i : core clock, async active-high reset
//   bus.rxd_i    : UART receive line
//   bus.txd_o    : UART transmit line
//   bus.busy_o   : packet in progress or response still being sent
module uart_alu
  import config_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 12000000,
  parameter int unsigned BAUD    = 115200,
  parameter logic [15:0] MAX_LEN = 16'd260
) (
  input logic       clk_i,
  input logic       rst_i,
  uart_alu_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;
  logic       tx_active;
  logic       txd;

  // ---------------- response FIFO (4 x 8) ----------------
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_count;
  logic       fifo_full, fifo_empty;
  logic       push, pop;
  logic [7:0] push_data;

  assign fifo_full  = (fifo_count == 3'd4);
  assign fifo_empty = (fifo_count == 3'd0);
  assign pop        = tx_ready && !fifo_empty;

  uart_alu_serdes #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_serdes (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rxd       (bus.rxd_i),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (fifo_mem[rd_ptr]),
    .tx_valid  (!fifo_empty),
    .tx_ready  (tx_ready),
    .tx_active (tx_active),
    .txd       (txd)
  );

  // NOTE: the FIFO storage has no reset; the pointers and count alone
  // define what is valid, which keeps the array out of the reset tree.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------- parser / accumulator ----------------
  parser_state_t state;
  mode_t         mode;
  logic [7:0]    len_lo;
  logic [15:0]   remaining;
  logic [1:0]    byte_idx;
  logic [1:0]    resp_idx;
  logic [23:0]   word_buf;
  logic [31:0]   acc;
  logic [31:0]   mul_a, mul_b, prod;
  logic [4:0]    mul_cnt;
  logic          busy;

  logic [15:0] len_full;
  logic [31:0] word_next;
  logic [31:0] acc_next;
  logic [31:0] mul_part;
  logic        last_byte;

  assign len_full  = {rx_data, len_lo};
  // Little-endian word completed by the byte currently on rx_data.
  assign word_next = {rx_data, word_buf};
  assign acc_next  = (byte_idx == 2'd3) ? acc + word_next : acc;
  assign mul_part  = mul_b[0] ? mul_a : 32'd0;
  assign last_byte = (remaining == 16'd1);

  // ADD32 pushes its LSB on the same edge as the last payload byte so the
  // response starts within two cycles; the other three bytes follow in RESP.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value held and infer a latch.
  always_comb begin
    push      = 1'b0;
    push_data = rx_data;
    if (state == ST_DATA && rx_valid && !fifo_full) begin
      if (mode == MODE_ECHO) begin
        push = 1'b1;
      end else if (mode == MODE_ADD && last_byte) begin
        push      = 1'b1;
        push_data = acc_next[7:0];
      end
    end else if (state == ST_RESP && mode != MODE_ECHO && !fifo_full) begin
      push      = 1'b1;
      push_data = acc[{resp_idx, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      mode      <= MODE_ECHO;
      len_lo    <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      resp_idx  <= '0;
      word_buf  <= '0;
      acc       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      prod      <= '0;
      mul_cnt   <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state != ST_IDLE) || !fifo_empty || tx_active;
      case (state)
        ST_IDLE: begin
          // Unknown bytes are dropped here, which resynchronises the stream.
          if (rx_valid) begin
            case (rx_data)
              OP_ECHO:  begin mode <= MODE_ECHO; state <= ST_RSVD; end
              OP_ADD32: begin mode <= MODE_ADD;  state <= ST_RSVD; end
              OP_MUL32: begin mode <= MODE_MUL;  state <= ST_RSVD; end
              default:  state <= ST_IDLE;
            endcase
          end
        end
        ST_RSVD: begin
          if (rx_valid) state <= ST_LEN_LO;
        end
        ST_LEN_LO: begin
          if (rx_valid) begin
            len_lo <= rx_data;
            state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (rx_valid) begin
            byte_idx  <= '0;
            resp_idx  <= '0;
            word_buf  <= '0;
            remaining <= len_full - 16'd4;
            acc       <= (mode == MODE_MUL) ? 32'd1 : 32'd0;
            if (len_full < 16'd4 || len_full > MAX_LEN)
              state <= ST_IDLE;
            else if (len_full == 16'd4)
              state <= (mode == MODE_ECHO) ? ST_IDLE : ST_RESP;
            else
              state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            remaining <= remaining - 16'd1;
            byte_idx  <= byte_idx + 2'd1;
            word_buf  <= {rx_data, word_buf[23:8]};
            case (mode)
              MODE_ECHO: begin
                if (last_byte) state <= ST_IDLE;
              end
              MODE_ADD: begin
                acc <= acc_next;
                if (last_byte) begin
                  state    <= ST_RESP;
                  resp_idx <= push ? 2'd1 : 2'd0;
                end
              end
              MODE_MUL: begin
                // Trailing bytes of a partial word never start a multiply.
                if (byte_idx == 2'd3) begin
                  mul_a   <= acc;
                  mul_b   <= word_next;
                  prod    <= '0;
                  mul_cnt <= '0;
                  state   <= ST_EXEC;
                end else if (last_byte) begin
                  state <= ST_RESP;
                end
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_EXEC: begin
          // Shift-add, one multiplier bit per cycle; rx bytes are dropped.
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt + 5'd1;
          if (mul_cnt == 5'd31) begin
            acc   <= prod + mul_part;
            state <= (remaining == 16'd0) ? ST_RESP : ST_DATA;
          end else begin
            prod <= prod + mul_part;
          end
        end
        ST_RESP: begin
          if (mode == MODE_ECHO) begin
            state <= ST_IDLE;
          end else if (push) begin
            resp_idx <= resp_idx + 2'd1;
            if (resp_idx == 2'd3) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.txd_o  = txd;
  assign bus.busy_o = busy;

endmodule

// File: tb/tb_uart_alu.sv
// Directed bench for uart_alu: byte-level UART driver on rxd_i, UART
// decoder on txd_o collecting response bytes, hand-computed expectations.
module tb_uart_alu;

  localparam int unsigned CPB    = 16;
  localparam int unsigned BAUD   = 1000000;
  localparam int unsigned CLK_HZ = CPB * BAUD;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_alu_if bus ();

  uart_alu #(
    .CLK_HZ  (CLK_HZ),
    .BAUD    (BAUD),
    .MAX_LEN (16'd260)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vectors     = 0;
  int n_miscompares = 0;
  logic [7:0] rx_q [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    bus.rxd_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxd_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rxd_i = stop;
    repeat (CPB) @(negedge clk);
    bus.rxd_i = 1'b1;
    if (!stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_bytes(input bq_t bs);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    repeat (4) @(negedge clk);
    while (bus.busy_o !== 1'b0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_idle"}, {31'd0, bus.busy_o}, 32'd0);
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic check_resp(input string tag, input int n,
                            input logic [31:0] exp);
    logic [7:0] got;
    check({tag, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      check($sformatf("%s_b%0d", tag, i), {24'd0, got},
            {24'd0, exp[8*i +: 8]});
    end
    rx_q.delete();
  endtask

  // Response decoder: samples each bit near its centre.
  initial begin
    logic [7:0] b;
    wait (rst == 1'b0);
    forever begin
      @(negedge bus.txd_o);
      repeat (CPB / 2) @(negedge clk);
      if (bus.txd_o == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = bus.txd_o;
        end
        repeat (CPB) @(negedge clk);
        if (!rst) rx_q.push_back(b);
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bq_t pkt;
    int  cyc;

    bus.rxd_i = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_txd", {31'd0, bus.txd_o}, 32'd1);
    check("reset_busy", {31'd0, bus.busy_o}, 32'd0);
    rst = 1'b0;
    repeat (4 * CPB) @(negedge clk);

    // Resynchronisation: unknown opcodes dropped, 0x11 accepted.
    pkt = '{8'hFF, 8'h88, 8'h30, 8'h00};
    send_bytes(pkt);
    repeat (4) @(negedge clk);
    check("unknown_busy", {31'd0, bus.busy_o}, 32'd0);
    send_byte(8'h11);
    repeat (4 * CPB) @(negedge clk);
    check("rsvd_busy", {31'd0, bus.busy_o}, 32'd1);
    check("rsvd_txd", {31'd0, bus.txd_o}, 32'd1);
    check("rsvd_noresp", rx_q.size(), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // ECHO
    pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    send_bytes(pkt);
    wait_idle("echo");
    check_resp("echo", 3, 32'h00434241);

    // ADD32 with wrap-around
    pkt = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
            8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_bytes(pkt);
    wait_idle("add_wrap");
    check_resp("add_wrap", 4, 32'h00000000);

    // MUL32: 1 * 3 * 5
    pkt = '{8'h11, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
            8'h05, 8'h00, 8'h00, 8'h00};
    send_bytes(pkt);
    wait_idle("mul");
    check_resp("mul", 4, 32'h0000000F);

    // Framing error on second payload byte: parser still needs one more.
    pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41};
    send_bytes(pkt);
    send_byte(8'h42, 1'b0);
    send_byte(8'h43);
    repeat (14 * CPB) @(negedge clk);
    check("frame_still_busy", {31'd0, bus.busy_o}, 32'd1);
    send_byte(8'h44);
    wait_idle("frame");
    check_resp("frame", 3, 32'h00444341);

    // Length below minimum: no response, next packet fine.
    pkt = '{8'h10, 8'h00, 8'h02, 8'h00};
    send_bytes(pkt);
    repeat (4 * CPB) @(negedge clk);
    check("short_busy", {31'd0, bus.busy_o}, 32'd0);
    check("short_noresp", rx_q.size(), 0);
    pkt = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
            8'h10, 8'h20, 8'h30, 8'h40};
    send_bytes(pkt);
    wait_idle("add_after_short");
    check_resp("add_after_short", 4, 32'h44332211);

    // Length 261 exceeds MAX_LEN.
    pkt = '{8'h10, 8'h00, 8'h05, 8'h01};
    send_bytes(pkt);
    repeat (4 * CPB) @(negedge clk);
    check("long_busy", {31'd0, bus.busy_o}, 32'd0);
    check("long_noresp", rx_q.size(), 0);

    // Zero payloads.
    pkt = '{8'h11, 8'h00, 8'h04, 8'h00};
    send_bytes(pkt);
    wait_idle("mul_empty");
    check_resp("mul_empty", 4, 32'h00000001);
    pkt = '{8'h10, 8'h00, 8'h04, 8'h00};
    send_bytes(pkt);
    wait_idle("add_empty");
    check_resp("add_empty", 4, 32'h00000000);

    // ADD32 with two trailing bytes ignored.
    pkt = '{8'h10, 8'h00, 8'h0A, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
            8'hAA, 8'hBB};
    send_bytes(pkt);
    wait_idle("add_trail");
    check_resp("add_trail", 4, 32'h00000002);

    // Reset during an echo transmission, mid-packet.
    pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h41, 8'h42};
    send_bytes(pkt);
    cyc = 0;
    while (bus.txd_o !== 1'b0 && cyc < 40 * CPB) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_txd_low_seen", {31'd0, bus.txd_o}, 32'd0);
    rst = 1'b1;
    #1;
    check("rst_txd_high", {31'd0, bus.txd_o}, 32'd1);
    check("rst_busy_low", {31'd0, bus.busy_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    rx_q.delete();
    pkt = '{8'h10, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_bytes(pkt);
    wait_idle("add_after_rst");
    check_resp("add_after_rst", 4, 32'h00000005);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/uart_alu.md
Name: uart_alu

Overview:
- Serial-attached arithmetic block: receives 8N1 UART bytes on rxd_i, parses command packets, computes the result, and returns it on txd_o.
- Sits behind the FPGA top-level UART pins; the host (or the bench's byte-sending runner) is the only peer.
- Packet format, in byte order: opcode, reserved, length LSB, length MSB, then (length − 4) payload bytes. Multi-byte operands are little-endian.

Parameters:
- CLK_HZ, 12000000, core clock frequency.
- BAUD, 115200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, rounded down.
- MAX_LEN, 16'd260, largest accepted packet length in bytes, header included.

Ports:
- clk_i  input  1  core clock; all state updates on its rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- rxd_i  input  1  UART receive line; idle high.
- txd_o  output  1  UART transmit line; idle high.
- busy_o  output  1  high from opcode accept until the last response stop bit has been sent.

Behaviour:
- Reset:
  - Parser in IDLE, TX FIFO empty, accumulator cleared.
  - txd_o=1, busy_o=0.
  - Reset is honoured mid-byte and mid-packet; partial data is discarded.
- RX:
  - rxd_i passes through a 2-FF synchroniser.
  - A start bit is detected on a falling edge and confirmed at mid-bit; a high level at mid-bit is treated as a glitch and the receiver returns to idle.
  - Data bits are sampled at mid-bit, LSB first.
  - If the stop bit samples 0, the byte is dropped (framing error) and no strobe is issued.
  - A valid byte produces a 1-cycle rx_valid strobe.
- Opcodes:
  - 0xEC ECHO: transmit the payload bytes unchanged.
  - 0x10 ADD32: payload is N 32-bit words; transmit the 32-bit sum, wrapping mod 2^32, as 4 bytes LSB first.
  - 0x11 MUL32: wrapping 32-bit product of N words; implemented as a sequential shift-add, 32 cycles per word.
- Parser FSM: IDLE → RSVD → LEN_LO → LEN_HI → DATA → (EXEC) → RESP → IDLE.
  - IDLE: bytes that are not a known opcode are silently discarded and the FSM stays in IDLE (resynchronisation rule).
  - RSVD: the byte is ignored.
  - Length check: if length < 4 or length > MAX_LEN, return to IDLE with no response.
  - ADD32/MUL32 with a payload size that is not a multiple of 4: trailing bytes are ignored; still respond.
  - Zero payload: ADD32 returns 0x00000000, MUL32 returns 0x00000001, ECHO sends nothing.
  - Echo latency: the first echoed start bit begins at most 2 cycles after the corresponding rx_valid.
  - ADD32 response starts at most 2 cycles after the last payload byte.
  - MUL32 response starts after the final multiply completes.
- Backpressure: bytes arriving while MUL32 is still computing are dropped. Senders must wait for busy_o=0 before sending the next packet.
- TX:
  - 8N1 framing, CLKS_PER_BIT cycles per bit.
  - Fed from a 4-entry byte FIFO.
  - In ECHO mode, FIFO overflow is impossible because the TX and RX bit rates are equal.

Decomposition:
- config_pkg holds:
  - opcode constants: OP_ECHO=8'hEC, OP_ADD32=8'h10, OP_MUL32=8'h11;
  - the parser state enum;
  - the CLKS_PER_BIT function.
- One sub-module, uart_alu_serdes, containing the UART rx and tx bit engines with a byte-strobe interface. Parser, accumulator and FIFO stay in the top module.

Test Plan:
- Reset, then send 0xFF, 0x88, 0x30, 0x00, 0x11 → first four bytes discarded as unknown opcodes; 0x11 is accepted and the parser waits in RSVD; txd_o stays high and no response is sent.
- ECHO: send EC 00 07 00 41 42 43 → response bytes 41 42 43, then idle and busy_o=0.
- ADD32: send 10 00 0C 00, then 01 00 00 00 and FF FF FF FF → response 00 00 00 00 (wrap-around).
- MUL32: send 11 00 0C 00, then 03 00 00 00 and 05 00 00 00 → response 0F 00 00 00.
- Framing error: a byte sent with stop bit = 0 mid-ECHO-payload → that byte is missing from the echo; the parser keeps counting the remaining bytes correctly.
- Bad length: send 10 00 02 00 → no response; a following valid ADD32 packet still works. Asserting rst_i mid-packet → txd_o=1 immediately and the next packet parses from IDLE.
